muldiv_arbiter: RTL

//  Shares the single M-extension multiplier/divider between NUM_REQ requesters (e.g. issue slots, debug).

---
 rtl/muldiv_arbiter.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/muldiv_arbiter.sv
// muldiv_arbiter: round-robin share of one M-extension multiply/divide unit
// between NUM_REQ requesters. A granted op is issued to the unit with a
// one-cycle start pulse. The arbiter waits for the unit's busy window to end,
// captures the result, and returns it tagged with the requester id.
//
// Ports
//   i_clk, i_rst                    clock, asynchronous active-high reset
//   i_req_valid/o_req_ready         per-requester handshake; ready is combinational, one-hot or zero
//   i_req_op/i_req_a/i_req_b        per-requester op and operands
//   o_resp_valid/i_resp_ready       result handshake
//   o_resp_id/o_resp_data           owning requester and result
//   o_mul_en/o_mul_op/o_mul_r1/r2   start pulse and operands to the unit
//   i_mul_busy/i_mul_rd             unit running flag and result
//   o_busy                          high whenever the arbiter is not idle
//
// Optional build macro MULDIV_FASTPATH_EN: divide-by-zero and signed-overflow
// divisions are answered directly, without using the unit.

package muldiv_arbiter_pkg;
  localparam int unsigned XLEN = 32;
  typedef logic [XLEN-1:0] word_t;
  typedef logic [2:0]      mul_op_t;
  localparam mul_op_t OP_MUL    = 3'd0;
  localparam mul_op_t OP_MULH   = 3'd1;
  localparam mul_op_t OP_MULHSU = 3'd2;
  localparam mul_op_t OP_MULHU  = 3'd3;
  localparam mul_op_t OP_DIV    = 3'd4;
  localparam mul_op_t OP_DIVU   = 3'd5;
  localparam mul_op_t OP_REM    = 3'd6;
  localparam mul_op_t OP_REMU   = 3'd7;
endpackage

module muldiv_arbiter
  import muldiv_arbiter_pkg::*;
#(
  parameter  int unsigned NUM_REQ = 2,
  localparam int unsigned IDW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic    [NUM_REQ-1:0]      i_req_valid,
  output logic    [NUM_REQ-1:0]      o_req_ready,
  input  mul_op_t [NUM_REQ-1:0]      i_req_op,
  input  word_t   [NUM_REQ-1:0]      i_req_a,
  input  word_t   [NUM_REQ-1:0]      i_req_b,
  output logic                       o_resp_valid,
  input  logic                       i_resp_ready,
  output logic    [IDW-1:0]          o_resp_id,
  output word_t                      o_resp_data,
  output logic                       o_mul_en,
  output mul_op_t                    o_mul_op,
  output word_t                      o_mul_r1,
  output word_t                      o_mul_r2,
  input  logic                       i_mul_busy,
  input  word_t                      i_mul_rd,
  output logic                       o_busy
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t         r_state, w_state_nxt;
  logic [IDW-1:0] r_rr_ptr, w_rr_ptr_nxt, w_gnt_id;
  logic           w_gnt_vld, w_grant, w_bypass;
  mul_op_t        w_gnt_op;
  word_t          w_gnt_a, w_gnt_b, w_bypass_data;

  logic           r_mul_en, r_resp_valid, r_busy;
  mul_op_t        r_mul_op;
  word_t          r_mul_r1, r_mul_r2, r_resp_data;
  logic [IDW-1:0] r_resp_id;

  // Round-robin pick: first valid requester starting at r_rr_ptr.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_id  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!w_gnt_vld && i_req_valid[IDW'((32'(r_rr_ptr) + i) % NUM_REQ)]) begin
        w_gnt_vld = 1'b1;
        w_gnt_id  = IDW'((32'(r_rr_ptr) + i) % NUM_REQ);
      end
    end
    w_gnt_op = i_req_op[w_gnt_id];
    w_gnt_a  = i_req_a[w_gnt_id];
    w_gnt_b  = i_req_b[w_gnt_id];
  end

  // Results the unit does not need to compute (RISC-V defined corner cases).
  always_comb begin
    w_bypass      = 1'b0;
    w_bypass_data = '0;
`ifdef MULDIV_FASTPATH_EN
    if (w_gnt_op[2]) begin
      if (w_gnt_b == '0) begin
        w_bypass      = 1'b1;
        w_bypass_data = (w_gnt_op == OP_DIV || w_gnt_op == OP_DIVU) ? '1 : w_gnt_a;
      end else if ((w_gnt_op == OP_DIV || w_gnt_op == OP_REM) &&
                   w_gnt_a == 32'h8000_0000 && w_gnt_b == 32'hFFFF_FFFF) begin
        w_bypass      = 1'b1;
        w_bypass_data = (w_gnt_op == OP_DIV) ? 32'h8000_0000 : '0;
      end
    end
`endif
  end

  assign w_grant = (r_state == S_IDLE) && w_gnt_vld;

  // FSM state register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_rr_ptr <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_rr_ptr <= w_rr_ptr_nxt;
    end
  end

  // Next state, pointer update and combinational grant.
  always_comb begin
    w_state_nxt  = r_state;
    w_rr_ptr_nxt = r_rr_ptr;
    o_req_ready  = '0;
    unique case (r_state)
      S_IDLE: begin
        if (w_gnt_vld) begin
          o_req_ready[w_gnt_id] = 1'b1;
          w_rr_ptr_nxt = (w_gnt_id == IDW'(NUM_REQ - 1)) ? '0 : w_gnt_id + IDW'(1);
          w_state_nxt  = w_bypass ? S_RESP : S_ISSUE;
        end
      end
      S_ISSUE: w_state_nxt = S_WAIT;
      S_WAIT:  if (!i_mul_busy) w_state_nxt = S_RESP;
      S_RESP:  if (i_resp_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Registered outputs; unit operands change only when a new op is issued.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_mul_en     <= 1'b0;
      r_mul_op     <= '0;
      r_mul_r1     <= '0;
      r_mul_r2     <= '0;
      r_resp_valid <= 1'b0;
      r_resp_id    <= '0;
      r_resp_data  <= '0;
      r_busy       <= 1'b0;
    end else begin
      r_mul_en     <= (w_state_nxt == S_ISSUE);
      r_resp_valid <= (w_state_nxt == S_RESP);
      r_busy       <= (w_state_nxt != S_IDLE);
      if (w_grant) begin
        r_resp_id <= w_gnt_id;
        if (w_bypass) begin
          r_resp_data <= w_bypass_data;
        end else begin
          r_mul_op <= w_gnt_op;
          r_mul_r1 <= w_gnt_a;
          r_mul_r2 <= w_gnt_b;
        end
      end
      if (r_state == S_WAIT && !i_mul_busy) r_resp_data <= i_mul_rd;
    end
  end

  assign o_mul_en     = r_mul_en;
  assign o_mul_op     = r_mul_op;
  assign o_mul_r1     = r_mul_r1;
  assign o_mul_r2     = r_mul_r2;
  assign o_resp_valid = r_resp_valid;
  assign o_resp_id    = r_resp_id;
  assign o_resp_data  = r_resp_data;
  assign o_busy       = r_busy;

endmodule
